// File: rtl/mem_arb_pkg.sv
// Shared encodings and sizing helpers for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Watchdog counter width; a one-cycle timeout still needs a 1-bit counter.
  function automatic int timer_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// Clear/enable cycle counter with a terminal-count flag, used as the BUSY watchdog.
module arb_wait_timer #(
  parameter int W        = 4,
  parameter int TERMINAL = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] count_r;

  // Counter: clear has priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (en) begin
      count_r <= count_r + W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == W'(TERMINAL));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the memory-map port between fetch (IF) and load/store (D),
// one transaction at a time, with wait-state support and a timeout watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  bus_re,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ready,
  output logic                  owner
);

  localparam int TIMER_W = timer_w(TIMEOUT_CYCLES);

  arb_state_e state_r;
  logic       last_served_r;
  logic       grant_d_s;
  logic       timeout_s;
  logic       timer_clr_s;
  logic       timer_en_s;

  // D wins when it is the only requester, or on a tie when IF was served last.
  always_comb begin
    grant_d_s = 1'b0;
    if (d_req && (!if_req || (last_served_r == OWN_IF))) begin
      grant_d_s = 1'b1;
    end else begin
      grant_d_s = 1'b0;
    end
  end

  assign timer_en_s  = (state_r == BUSY);
  assign timer_clr_s = (state_r != BUSY);

  arb_wait_timer #(
    .W       (TIMER_W),
    .TERMINAL(TIMEOUT_CYCLES - 1)
  ) u_wait_timer (
    .clk(clk),
    .rst(rst),
    .clr(timer_clr_s),
    .en (timer_en_s),
    .tc (timeout_s)
  );

  // Arbitration FSM; every output is a register written here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      last_served_r <= OWN_IF;
      owner         <= OWN_IF;
      bus_re        <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= {ADDR_WIDTH{1'b0}};
      bus_wdata     <= {DATA_WIDTH{1'b0}};
      if_done       <= 1'b0;
      if_rdata      <= {DATA_WIDTH{1'b0}};
      if_err        <= 1'b0;
      d_done        <= 1'b0;
      d_rdata       <= {DATA_WIDTH{1'b0}};
      d_err         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (if_req || d_req) begin
            owner         <= grant_d_s;
            last_served_r <= grant_d_s;
            state_r       <= BUSY;
            if (grant_d_s) begin
              bus_addr  <= d_addr;
              bus_wdata <= d_wdata;
              bus_we    <= d_we;
              bus_re    <= ~d_we;
            end else begin
              bus_addr  <= if_addr;
              bus_wdata <= {DATA_WIDTH{1'b0}};
              bus_we    <= 1'b0;
              bus_re    <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          // Ready beats a coincident timeout, so err is just the inverse of ready.
          if (bus_ready || timeout_s) begin
            bus_re  <= 1'b0;
            bus_we  <= 1'b0;
            state_r <= RESP;
            if (owner == OWN_D) begin
              d_done  <= 1'b1;
              d_rdata <= (bus_ready && !bus_we) ? bus_rdata : {DATA_WIDTH{1'b0}};
              d_err   <= ~bus_ready;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= bus_ready ? bus_rdata : {DATA_WIDTH{1'b0}};
              if_err   <= ~bus_ready;
            end
          end else begin
            state_r <= BUSY;
          end
        end
        RESP: begin
          if_done <= 1'b0;
          d_done  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          if_done <= 1'b0;
          d_done  <= 1'b0;
          bus_re  <= 1'b0;
          bus_we  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT_CYCLES = 16).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        bus_re;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        owner;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_done  (if_done),
    .if_rdata (if_rdata),
    .if_err   (if_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .bus_re   (bus_re),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ready(bus_ready),
    .owner    (owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, {25'd0, if_done, if_err, d_done, d_err, bus_re, bus_we, owner}, 32'd0);
    chk({tag, "_bus_addr"}, bus_addr, 32'd0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  initial begin
    logic expd;
    rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'd0; d_wdata = 32'd0; bus_rdata = 32'd0; bus_ready = 1'b0;

    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // IF-only fetch, ready immediately
    if_addr = 32'h0040_0004; if_req = 1'b1; bus_ready = 1'b1; bus_rdata = 32'h0000_0013;
    @(negedge clk);
    chk("if1_bus_re", {31'd0, bus_re}, 32'd1);
    chk("if1_bus_we", {31'd0, bus_we}, 32'd0);
    chk("if1_bus_addr", bus_addr, 32'h0040_0004);
    chk("if1_owner", {31'd0, owner}, 32'd0);
    chk("if1_done_early", {31'd0, if_done}, 32'd0);
    @(negedge clk);
    chk("if1_done", {31'd0, if_done}, 32'd1);
    chk("if1_rdata", if_rdata, 32'h0000_0013);
    chk("if1_err", {31'd0, if_err}, 32'd0);
    chk("if1_bus_re_off", {31'd0, bus_re}, 32'd0);
    chk("if1_d_done", {31'd0, d_done}, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    chk("if1_done_pulse", {31'd0, if_done}, 32'd0);

    // Both held continuously: D (store) first, then strict alternation
    d_we = 1'b1; d_addr = 32'h1001_0024; d_wdata = 32'h0000_00A5;
    if_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      expd = ((k % 2) == 0);
      @(negedge clk);
      chk($sformatf("rr%0d_owner", k), {31'd0, owner}, {31'd0, expd});
      chk($sformatf("rr%0d_bus_we", k), {31'd0, bus_we}, {31'd0, expd});
      chk($sformatf("rr%0d_bus_re", k), {31'd0, bus_re}, {31'd0, ~expd});
      chk($sformatf("rr%0d_bus_addr", k), bus_addr, expd ? 32'h1001_0024 : 32'h0040_0004);
      chk($sformatf("rr%0d_bus_wdata", k), bus_wdata, expd ? 32'h0000_00A5 : 32'd0);
      @(negedge clk);
      chk($sformatf("rr%0d_d_done", k), {31'd0, d_done}, {31'd0, expd});
      chk($sformatf("rr%0d_if_done", k), {31'd0, if_done}, {31'd0, ~expd});
      if (expd) chk($sformatf("rr%0d_d_rdata", k), d_rdata, 32'd0);
      else      chk($sformatf("rr%0d_if_rdata", k), if_rdata, 32'h0000_0013);
      @(negedge clk);
      chk($sformatf("rr%0d_pulse", k), {30'd0, d_done, if_done}, 32'd0);
    end
    if_req = 1'b0; d_req = 1'b0;

    // Load with 5 wait cycles
    d_we = 1'b0; d_addr = 32'h1001_0100; d_req = 1'b1; bus_ready = 1'b0; bus_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("ws%0d_bus_addr", i), bus_addr, 32'h1001_0100);
      chk($sformatf("ws%0d_bus_re", i), {31'd0, bus_re}, 32'd1);
      chk($sformatf("ws%0d_d_done", i), {31'd0, d_done}, 32'd0);
    end
    @(negedge clk);
    chk("ws5_bus_addr", bus_addr, 32'h1001_0100);
    bus_ready = 1'b1;
    @(negedge clk);
    chk("ws_d_done", {31'd0, d_done}, 32'd1);
    chk("ws_d_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("ws_d_err", {31'd0, d_err}, 32'd0);
    chk("ws_if_rdata_kept", if_rdata, 32'h0000_0013);
    bus_ready = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // Watchdog: ready never comes, abort after 16 BUSY cycles
    d_addr = 32'h2000_0000; d_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk($sformatf("to_busy%0d_bus_re", i), {31'd0, bus_re}, 32'd1);
    end
    @(negedge clk);
    chk("to_bus_re_off", {31'd0, bus_re}, 32'd0);
    chk("to_d_done", {31'd0, d_done}, 32'd1);
    chk("to_d_err", {31'd0, d_err}, 32'd1);
    chk("to_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    chk("to_d_done_pulse", {31'd0, d_done}, 32'd0);

    // Ready arrives in the same cycle as the timeout: ready wins
    d_req = 1'b1; bus_rdata = 32'h0000_0055;
    for (int i = 1; i <= 15; i++) @(negedge clk);
    chk("tie_bus_re", {31'd0, bus_re}, 32'd1);
    @(negedge clk);
    bus_ready = 1'b1;
    @(negedge clk);
    chk("tie_d_done", {31'd0, d_done}, 32'd1);
    chk("tie_d_err", {31'd0, d_err}, 32'd0);
    chk("tie_d_rdata", d_rdata, 32'h0000_0055);
    bus_ready = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a D store
    d_we = 1'b1; d_addr = 32'h1001_0024; d_wdata = 32'h0000_00A5; d_req = 1'b1;
    @(negedge clk);
    chk("rb_bus_we", {31'd0, bus_we}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_async");
    d_req = 1'b0;
    @(negedge clk);
    chk("rst_no_done", {31'd0, d_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle", {29'd0, d_done, bus_re, bus_we}, 32'd0);
    d_we = 1'b0; d_addr = 32'h1001_0100; if_addr = 32'h0040_0008;
    bus_ready = 1'b1; bus_rdata = 32'h0000_0077; if_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    chk("ra_owner", {31'd0, owner}, 32'd1);
    chk("ra_bus_re", {31'd0, bus_re}, 32'd1);
    chk("ra_bus_addr", bus_addr, 32'h1001_0100);
    @(negedge clk);
    chk("ra_d_done", {31'd0, d_done}, 32'd1);
    chk("ra_d_rdata", d_rdata, 32'h0000_0077);
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
